serial_pattern_detector: RTL and testbench
==========================================

Name: serial_pattern_detector

Overview:
- Receive-side block for the single-bit serial stream produced by the `y` output of structural_model.
- Samples the stream on qualified clock edges and detects the overlapping pattern 1011 with a Moore FSM.
- Counts matches in a saturating counter.
- Deserializes the stream MSB-first into parallel words.
- Sits directly downstream of the generator in the Activity 3 top level, clocked by the same `clk`.

Parameters:
- CNT_W, 8: width of the match counter. The counter saturates at 2^CNT_W-1.
- WORD_W, 8: deserializer word width in bits. Legal values are 2..16.

Ports:
- clk  input  1  system clock; rising edge active.
- reset  input  1  synchronous, active-high reset.
- x_in  input  1  serial data bit; connected to the generator's `y`.
- x_valid  input  1  qualifies `x_in`; a bit is consumed only on a rising edge where `x_valid`=1.
- clear_cnt  input  1  synchronous clear of `match_count`.
- match  output  1  one-cycle pulse; high the cycle after the bit that completes 1011.
- match_count  output  CNT_W  saturating count of matches since reset or clear.
- word_out  output  WORD_W  last completed word, MSB = first received bit.
- word_valid  output  1  one-cycle pulse when `word_out` updates.
- state_dbg  output  2  current FSM state encoding, for debug and the bench.

Behaviour:
- Clock and reset: one clock, `clk`; reset is synchronous and active-high (port `reset`), sampled on the rising edge of `clk`.
- Reset values: state=IDLE, `match`=0, `match_count`=0, `word_out`=0, `word_valid`=0, internal bit counter=0, internal shift register=0.
- Reset mid-operation: has priority over all other inputs. It discards a partial word and a partial pattern prefix. No `match` or `word_valid` is produced from pre-reset bits.
- FSM states and encoding: IDLE=0, GOT1=1, GOT10=2, GOT101=3. Transitions occur only when `x_valid`=1:
  - IDLE: `x_in`=1 -> GOT1; `x_in`=0 -> IDLE.
  - GOT1: 0 -> GOT10; 1 -> GOT1.
  - GOT10: 1 -> GOT101; 0 -> IDLE.
  - GOT101: 1 -> GOT1 with `match` asserted next cycle (overlap on suffix "1"); 0 -> GOT10 (overlap on suffix "10").
- `x_valid`=0: state, shift register and bit counter hold; `match`=0 and `word_valid`=0 that cycle.
- `match` latency: registered. It goes high exactly 1 clk after the completing bit is sampled and stays high for 1 cycle only. Back-to-back matches cannot occur sooner than 3 valid bits apart (1011011).
- `match_count` update rules:
  - Increments on the same edge that sets `match`, so `count` and `match` update together.
  - Holds at 2^CNT_W-1 once saturated; there is no wrap-around.
  - `clear_cnt`=1 sets count to 0. If a match occurs on the same edge as `clear_cnt`, clear wins and count=0, but `match` still pulses.
- Deserializer, bit handling:
  - Each valid bit shifts in: shift = {shift[WORD_W-2:0], x_in}.
  - The bit counter runs 0..WORD_W-1 and wraps to 0 after the last bit of a word.
- Deserializer, word completion:
  - On the valid bit with counter=WORD_W-1, `word_out` <= {shift[WORD_W-2:0], x_in} and `word_valid` is high the next cycle for 1 cycle.
  - `word_out` holds between completions.
  - The first bit after reset is the MSB of word 0.
- Independence: pattern detection is independent of word boundaries and spans words freely.

Decomposition:
- Package serial_rx_pkg:
  - `typedef enum logic [1:0] {IDLE, GOT1, GOT10, GOT101} det_state_t;`
  - `localparam logic [3:0] PATTERN = 4'b1011;`
- Sub-module serial_deser (params WORD_W):
  - Ports: `clk`, `reset`, `x_in`, `x_valid`, `word_out`, `word_valid`.
  - Owns the shift register and the bit counter.
- The top level holds the FSM, the `match` register and the counter.

Test Plan:
- Reset check: hold `reset`=1 for 2 cycles with `x_in`=1 and `x_valid`=1 -> `match`=0, `match_count`=0, `word_valid`=0, `state_dbg`=0 throughout.
- Overlap detection: valid bits 1,0,1,1,0,1,1 on consecutive cycles -> `match` pulses 1 cycle after the 4th and 7th bits; `match_count`=2; final `state_dbg`=1.
- Gapped input: same bits with `x_valid` toggling 1/0 each cycle -> identical match count of 2. `match` never lasts more than 1 cycle. State holds on the gap cycles.
- Deserializer: 8 valid bits 1,0,1,1,0,0,1,1 -> `word_valid` pulses once, `word_out`=8'hB3. Also 1 match, fired after the 4th bit.
- Saturation and clear: with CNT_W=2, feed 5 matches -> count 1,2,3,3,3. Then assert `clear_cnt` on a matching edge -> count=0 and `match`=1.
- Reset mid-stream: 5 valid bits 1,0,1,1,0, then `reset` for 1 cycle, then 1,1 -> no second match; `word_valid` absent until 8 post-reset bits are received.

Source files
------------

// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial receive path: detector state
// encoding and the bit pattern the detector looks for.
package serial_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GOT1   = 2'd1,
    GOT10  = 2'd2,
    GOT101 = 2'd3
  } det_state_t;

  // First-received bit is PATTERN[3].
  localparam logic [3:0] PATTERN = 4'b1011;

endpackage : serial_rx_pkg

// File: rtl/serial_deser.sv
// MSB-first deserializer: collects WORD_W qualified bits and presents each
// completed word with a one-cycle valid pulse.
module serial_deser #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              x_in,
  input  logic              x_valid,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid
);

  localparam int CW = $clog2(WORD_W);
  localparam logic [CW-1:0] LAST_IDX = CW'(WORD_W - 1);

  // Only WORD_W-1 bits need storing; the final bit of a word goes straight
  // from x_in into word_out.
  logic [WORD_W-2:0] shift_q, shift_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              word_valid_q, word_valid_d;

  always_comb begin
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (x_valid) begin
      shift_d = {shift_q[WORD_W-3:0], x_in};
      if (bit_cnt_q == LAST_IDX) begin
        bit_cnt_d    = '0;
        word_d       = {shift_q, x_in};
        word_valid_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = word_valid_q;

endmodule : serial_deser

// File: rtl/serial_pattern_detector.sv
// Serial receiver: overlapping 1011 detector (Moore FSM) with a saturating
// match counter, plus a word deserializer running on the same bit stream.
module serial_pattern_detector
  import serial_rx_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              x_in,
  input  logic              x_valid,
  input  logic              clear_cnt,
  output logic              match,
  output logic [CNT_W-1:0]  match_count,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic [1:0]        state_dbg
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  det_state_t       state_q, state_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    state_d = state_q;
    match_d = 1'b0;
    if (x_valid) begin
      unique case (state_q)
        IDLE:   state_d = (x_in == PATTERN[3]) ? GOT1 : IDLE;
        GOT1:   state_d = (x_in == PATTERN[2]) ? GOT10 : GOT1;
        GOT10:  state_d = (x_in == PATTERN[1]) ? GOT101 : IDLE;
        GOT101: begin
          // Overlap: a completed 1011 already ends in "1"; a miss leaves "10".
          if (x_in == PATTERN[0]) begin
            state_d = GOT1;
            match_d = 1'b1;
          end else begin
            state_d = GOT10;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Clear beats a coincident match; the match pulse itself is unaffected.
  always_comb begin
    count_d = count_q;
    if (clear_cnt) begin
      count_d = '0;
    end else if (match_d && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      match_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      count_q <= count_d;
    end
  end

  serial_deser #(
    .WORD_W(WORD_W)
  ) u_deser (
    .clk       (clk),
    .reset     (reset),
    .x_in      (x_in),
    .x_valid   (x_valid),
    .word_out  (word_out),
    .word_valid(word_valid)
  );

  assign match       = match_q;
  assign match_count = count_q;
  assign state_dbg   = state_q;

endmodule : serial_pattern_detector

// File: tb/tb_serial_pattern_detector.sv
// Directed bench for serial_pattern_detector: a vector table driven through
// two instances (8-bit and 2-bit counters) plus a hand-written clear sequence.
module tb_serial_pattern_detector;

  logic       clk = 1'b0;
  logic       reset, x_in, x_valid, clear_cnt;
  logic       match8, match2, wv8, wv2;
  logic [7:0] cnt8, word8, word2;
  logic [1:0] cnt2, st8, st2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_pattern_detector #(.CNT_W(8), .WORD_W(8)) dut8 (
    .clk(clk), .reset(reset), .x_in(x_in), .x_valid(x_valid), .clear_cnt(clear_cnt),
    .match(match8), .match_count(cnt8), .word_out(word8), .word_valid(wv8), .state_dbg(st8)
  );

  serial_pattern_detector #(.CNT_W(2), .WORD_W(8)) dut2 (
    .clk(clk), .reset(reset), .x_in(x_in), .x_valid(x_valid), .clear_cnt(clear_cnt),
    .match(match2), .match_count(cnt2), .word_out(word2), .word_valid(wv2), .state_dbg(st2)
  );

  typedef struct {
    logic       rst, x, v, clr;
    logic       m;
    logic [7:0] c8;
    logic [1:0] c2;
    logic       wv;
    logic [7:0] w;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic x, input logic v, input logic clr,
                     input logic m, input logic [7:0] c8, input logic [1:0] c2,
                     input logic wv, input logic [7:0] w, input logic [1:0] st);
    vec_t e;
    e.rst = rst; e.x = x; e.v = v; e.clr = clr;
    e.m = m; e.c8 = c8; e.c2 = c2; e.wv = wv; e.w = w; e.st = st;
    vecs.push_back(e);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    int pulses;
    logic [1:0] tri_bits[3];
    reset = 1'b1; x_in = 1'b0; x_valid = 1'b0; clear_cnt = 1'b0;

    // Reset held with live input.
    add(1,1,1,0, 0,0,0,0,8'h00,0);
    add(1,1,1,0, 0,0,0,0,8'h00,0);
    // Overlap: 1011011.
    add(0,1,1,0, 0,0,0,0,8'h00,1);
    add(0,0,1,0, 0,0,0,0,8'h00,2);
    add(0,1,1,0, 0,0,0,0,8'h00,3);
    add(0,1,1,0, 1,1,1,0,8'h00,1);
    add(0,0,1,0, 0,1,1,0,8'h00,2);
    add(0,1,1,0, 0,1,1,0,8'h00,3);
    add(0,1,1,0, 1,2,2,0,8'h00,1);
    add(1,0,0,0, 0,0,0,0,8'h00,0);
    // Gapped 1011011; gap bits chosen so an ungated FSM would move.
    add(0,1,1,0, 0,0,0,0,8'h00,1);
    add(0,0,0,0, 0,0,0,0,8'h00,1);
    add(0,0,1,0, 0,0,0,0,8'h00,2);
    add(0,1,0,0, 0,0,0,0,8'h00,2);
    add(0,1,1,0, 0,0,0,0,8'h00,3);
    add(0,0,0,0, 0,0,0,0,8'h00,3);
    add(0,1,1,0, 1,1,1,0,8'h00,1);
    add(0,0,0,0, 0,1,1,0,8'h00,1);
    add(0,0,1,0, 0,1,1,0,8'h00,2);
    add(0,1,0,0, 0,1,1,0,8'h00,2);
    add(0,1,1,0, 0,1,1,0,8'h00,3);
    add(0,0,0,0, 0,1,1,0,8'h00,3);
    add(0,1,1,0, 1,2,2,0,8'h00,1);
    add(0,0,0,0, 0,2,2,0,8'h00,1);
    add(1,0,0,0, 0,0,0,0,8'h00,0);
    // Deserializer: 10110011 -> B3.
    add(0,1,1,0, 0,0,0,0,8'h00,1);
    add(0,0,1,0, 0,0,0,0,8'h00,2);
    add(0,1,1,0, 0,0,0,0,8'h00,3);
    add(0,1,1,0, 1,1,1,0,8'h00,1);
    add(0,0,1,0, 0,1,1,0,8'h00,2);
    add(0,0,1,0, 0,1,1,0,8'h00,0);
    add(0,1,1,0, 0,1,1,0,8'h00,1);
    add(0,1,1,0, 0,1,1,1,8'hB3,1);
    add(0,0,0,0, 0,1,1,0,8'hB3,1);
    // Clear, then five "011" matches from GOT1: saturation on the 2-bit counter.
    add(0,1,0,1, 0,0,0,0,8'hB3,1);
    for (int k = 1; k <= 5; k++) begin
      logic [1:0] cp, ck;
      logic [7:0] wa, wb;
      cp = (k - 1 > 3) ? 2'd3 : 2'((k - 1));
      ck = (k > 3) ? 2'd3 : 2'(k);
      wa = (k <= 2) ? 8'hB3 : 8'h6D;
      wb = (k <= 3) ? 8'hB3 : 8'h6D;
      add(0,0,1,0, 0,8'(k-1),cp,0,wb,2);
      add(0,1,1,0, 0,8'(k-1),cp,(k==3),wa,3);
      add(0,1,1,0, 1,8'(k),ck,0,wa,1);
    end
    // Clear on a matching edge; word B6 completes on the leading 0.
    add(0,0,1,0, 0,5,3,1,8'hB6,2);
    add(0,1,1,0, 0,5,3,0,8'hB6,3);
    add(0,1,1,1, 1,0,0,0,8'hB6,1);
    add(0,0,0,0, 0,0,0,0,8'hB6,1);
    // Reset mid-stream after 10110, then 8 fresh bits 11000001.
    add(0,1,1,0, 0,0,0,0,8'hB6,1);
    add(0,0,1,0, 0,0,0,0,8'hB6,2);
    add(0,1,1,0, 0,0,0,0,8'hB6,3);
    add(0,1,1,0, 1,1,1,0,8'hB6,1);
    add(0,0,1,0, 0,1,1,0,8'hB6,2);
    add(1,1,1,0, 0,0,0,0,8'h00,0);
    add(0,1,1,0, 0,0,0,0,8'h00,1);
    add(0,1,1,0, 0,0,0,0,8'h00,1);
    add(0,0,1,0, 0,0,0,0,8'h00,2);
    add(0,0,1,0, 0,0,0,0,8'h00,0);
    add(0,0,1,0, 0,0,0,0,8'h00,0);
    add(0,0,1,0, 0,0,0,0,8'h00,0);
    add(0,0,1,0, 0,0,0,0,8'h00,0);
    add(0,1,1,0, 0,0,0,1,8'hC1,1);
    add(0,0,0,0, 0,0,0,0,8'hC1,1);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; x_in = vecs[i].x; x_valid = vecs[i].v; clear_cnt = vecs[i].clr;
      @(negedge clk);
      $display("vec %0d rst=%0b x=%0b v=%0b clr=%0b -> match=%0b cnt8=%0d cnt2=%0d wv=%0b word=%02h st=%0d",
               i, reset, x_in, x_valid, clear_cnt, match8, cnt8, cnt2, wv8, word8, st8);
      chk("match8", i, 32'(match8), 32'(vecs[i].m));
      chk("match2", i, 32'(match2), 32'(vecs[i].m));
      chk("count8", i, 32'(cnt8), 32'(vecs[i].c8));
      chk("count2", i, 32'(cnt2), 32'(vecs[i].c2));
      chk("word_valid", i, 32'(wv8), 32'(vecs[i].wv));
      chk("word_out", i, 32'(word8), 32'(vecs[i].w));
      chk("state", i, 32'(st8), 32'(vecs[i].st));
      chk("state2", i, 32'(st2), 32'(vecs[i].st));
    end

    // Hand sequence: clear held across 1011011 keeps count at 0 while match
    // still pulses twice, never on consecutive cycles.
    reset = 1'b1; x_valid = 1'b0; clear_cnt = 1'b0;
    @(negedge clk);
    reset = 1'b0; clear_cnt = 1'b1; x_valid = 1'b1;
    pulses = 0;
    begin
      logic [6:0] seq;
      logic prev_m;
      seq = 7'b1011011;
      prev_m = 1'b0;
      for (int b = 6; b >= 0; b--) begin
        x_in = seq[b];
        @(negedge clk);
        $display("hand bit=%0b -> match=%0b cnt8=%0d st=%0d", x_in, match8, cnt8, st8);
        if (match8) pulses++;
        chk("hold_clear_cnt", b, 32'(cnt8), 32'd0);
        if (prev_m) chk("pulse_width", b, 32'(match8), 32'd0);
        prev_m = match8;
      end
    end
    chk("hold_clear_pulses", 0, 32'(pulses), 32'd2);
    chk("hold_clear_state", 0, 32'(st8), 32'd1);
    clear_cnt = 1'b0; x_valid = 1'b0;
    @(negedge clk);
    chk("match_drops", 0, 32'(match8), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serial_pattern_detector
